// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe_if
// Description : Valid/ready bundle between the decode-side source, the
//               immediate extender pipe and its consumer (ALU-source and
//               PC-target muxes).
//               Input side  : in_valid, in_ready, instr, ImmSrc, in_tag
//               Output side : out_valid, out_ready, ImmOp, imm_illegal, out_tag
//               master : view of the environment (drives requests, accepts
//                        results)
//               slave  : view of the extender pipe
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [2:0]            ImmSrc;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ImmOp;
    logic                  imm_illegal;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, instr, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ImmOp, imm_illegal, out_tag
    );

    modport slave (
        input  in_valid, instr, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, ImmOp, imm_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : RV32I immediate generator (I/S/B/U/J) with sign extension to
//               DATA_WIDTH (>= 32). The extended immediate is captured at
//               input accept into a 2-entry main/skid buffer and presented on
//               a valid/ready output together with a sideband tag.
// Ports       : clk   - clock, all state updates on rising edge
//               rst   - synchronous active-high reset (clears data too)
//               flush - synchronous flush, discards all buffered entries
//               bus   - imm_extend_pipe_if.slave (input and output handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    imm_extend_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;

    logic [DATA_WIDTH-1:0] main_imm_q, main_imm_d;
    logic                  main_ill_q, main_ill_d;
    logic [TAG_WIDTH-1:0]  main_tag_q, main_tag_d;
    logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_d;
    logic                  skid_ill_q, skid_ill_d;
    logic [TAG_WIDTH-1:0]  skid_tag_q, skid_tag_d;

    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_transfer;

    // ------------------------------------------------------------------
    // Format decode and sign extension of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (bus.ImmSrc)
            3'b000: w_imm = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
            3'b001: w_imm = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:25],
                             bus.instr[11:7]};
            3'b010: w_imm = {{(DATA_WIDTH-13){bus.instr[31]}}, bus.instr[31],
                             bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
            3'b011: w_imm = {{(DATA_WIDTH-32){bus.instr[31]}}, bus.instr[31:12],
                             12'h000};
            3'b100: w_imm = {{(DATA_WIDTH-21){bus.instr[31]}}, bus.instr[31],
                             bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
            default: w_illegal = 1'b1;
        endcase
    end

    // in_ready depends only on the state register, so there is no
    // combinational path from out_ready back to the source.
    assign bus.in_ready    = (state_q != ST_FULL);
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.ImmOp       = main_imm_q;
    assign bus.imm_illegal = main_ill_q;
    assign bus.out_tag     = main_tag_q;

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_transfer = bus.out_valid & bus.out_ready;

    // ------------------------------------------------------------------
    // Next state and buffer loads
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_ill_d = main_ill_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;

        if (flush) begin
            // Input offered in the flush cycle is dropped; a transfer in the
            // same cycle has already been consumed downstream.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d    = ST_ONE;
                        main_imm_d = w_imm;
                        main_ill_d = w_illegal;
                        main_tag_d = bus.in_tag;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_transfer) begin
                        main_imm_d = w_imm;
                        main_ill_d = w_illegal;
                        main_tag_d = bus.in_tag;
                    end else if (w_accept) begin
                        state_d    = ST_FULL;
                        skid_imm_d = w_imm;
                        skid_ill_d = w_illegal;
                        skid_tag_d = bus.in_tag;
                    end else if (w_transfer) begin
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_transfer) begin
                        state_d    = ST_ONE;
                        main_imm_d = skid_imm_q;
                        main_ill_d = skid_ill_q;
                        main_tag_d = skid_tag_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_imm_q <= '0;
            main_ill_q <= 1'b0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_ill_q <= main_ill_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe. A 32-bit instance is
//               exercised with a vector table, backpressure, flush and reset
//               sequences against a scoreboard queue; a 64-bit instance checks
//               sign extension beyond bit 31.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic clk;
    logic rst;
    logic flush;

    imm_extend_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) b();
    imm_extend_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(5)) b64();

    imm_extend_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b)
    );

    imm_extend_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp_imm;
        logic        exp_ill;
    } vec_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_xfer = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: shift-based sign extension of 32-bit forms.
    function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src);
        logic signed [31:0] s;
        logic [31:0]        v;
        logic [12:0]        bi;
        logic [20:0]        ji;
        s = $signed(ins) >>> 20;
        case (src)
            3'd0: v = s;
            3'd1: v = {s[31:5], ins[11:7]};
            3'd2: begin
                bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v  = $signed({bi, 19'b0}) >>> 19;
            end
            3'd3: v = {ins[31:12], 12'h000};
            3'd4: begin
                ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v  = $signed({ji, 11'b0}) >>> 11;
            end
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, {32{v[31]}}, v};
    endfunction

    // Output monitor: samples at the falling edge what happens at the next rise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (b.out_valid && b.out_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    chk("unexpected_output_tag", {59'd0, b.out_tag}, 64'h1_0000);
                end else begin
                    e = sb.pop_front();
                    chk("out_imm", {32'd0, b.ImmOp}, {32'd0, e.imm});
                    chk("out_ill", {63'd0, b.imm_illegal}, {63'd0, e.ill});
                    chk("out_tag", {59'd0, b.out_tag}, {59'd0, e.tag});
                end
            end
            if (flush) sb.delete();
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag,
                        input logic [31:0] ei, input logic eill);
        int n;
        n = 0;
        b.instr    = ins;
        b.ImmSrc   = src;
        b.in_tag   = tag;
        b.in_valid = 1'b1;
        @(negedge clk);
        while (!b.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b.in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", tag);
        end else begin
            sb.push_back('{imm: ei, ill: eill, tag: tag});
        end
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[13];
        logic [31:0] ins;
        logic [2:0]  src;
        logic [64:0] m;
        logic        done;
        int          x0;

        tbl[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0};
        tbl[1]  = '{32'h7FF00093, 3'b000, 32'h000007FF, 1'b0};
        tbl[2]  = '{32'hFE112E23, 3'b001, 32'hFFFFFFFC, 1'b0};
        tbl[3]  = '{32'h7E000FA3, 3'b001, 32'h000007FF, 1'b0};
        tbl[4]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0};
        tbl[5]  = '{32'h00000080, 3'b010, 32'h00000800, 1'b0};
        tbl[6]  = '{32'h12345037, 3'b011, 32'h12345000, 1'b0};
        tbl[7]  = '{32'h80000537, 3'b011, 32'h80000000, 1'b0};
        tbl[8]  = '{32'hFFFFF06F, 3'b100, 32'hFFFFFFFE, 1'b0};
        tbl[9]  = '{32'h0080006F, 3'b100, 32'h00000008, 1'b0};
        tbl[10] = '{32'hDEADBEEF, 3'b101, 32'h00000000, 1'b1};
        tbl[11] = '{32'hFFFFFFFF, 3'b110, 32'h00000000, 1'b1};
        tbl[12] = '{32'h12345678, 3'b111, 32'h00000000, 1'b1};

        rst = 1'b1;   flush = 1'b0;
        b.in_valid = 1'b0;   b.instr = '0;   b.ImmSrc = '0;   b.in_tag = '0;
        b.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.instr = '0; b64.ImmSrc = '0; b64.in_tag = '0;
        b64.out_ready = 1'b1;
        done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, b.in_ready}, 64'd1);
        chk("rst_imm", {32'd0, b.ImmOp}, 64'd0);
        chk("rst_ill", {63'd0, b.imm_illegal}, 64'd0);
        chk("rst_tag", {59'd0, b.out_tag}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single I-type: one-cycle latency, then back to empty
        send(32'hFFF00093, 3'b000, 5'd1, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        chk("lat_out_valid", {63'd0, b.out_valid}, 64'd1);
        @(negedge clk);
        chk("lat_empty_after", {63'd0, b.out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Vector table, streamed back-to-back
        for (int i = 0; i < 13; i++)
            send(tbl[i].instr, tbl[i].src, 5'(i + 1), tbl[i].exp_imm, tbl[i].exp_ill);
        drain();

        // Backpressure: A, B fill the buffer, C waits
        b.out_ready = 1'b0;
        x0 = n_xfer;
        send(32'h00100093, 3'b000, 5'd1, 32'h00000001, 1'b0);
        send(32'h00200093, 3'b000, 5'd2, 32'h00000002, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_full", {63'd0, b.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        fork
            send(32'h00300093, 3'b000, 5'd3, 32'h00000003, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("bp_in_ready_hold", {63'd0, b.in_ready}, 64'd0);
                chk("bp_out_tag_hold", {59'd0, b.out_tag}, 64'd1);
                @(posedge clk);
                #1 b.out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_back", {63'd0, b.in_ready}, 64'd1);
            end
        join
        drain();
        repeat (2) @(posedge clk);
        #1 chk("bp_xfer_count", 64'(n_xfer - x0), 64'd3);

        // Random formats with random backpressure
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    ins = $urandom;
                    src = 3'($urandom_range(0, 7));
                    m   = model(ins, src);
                    send(ins, src, 5'(k), m[31:0], m[64]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 b.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        b.out_ready = 1'b1;
        drain();

        // Flush while full, with an input offered in the flush cycle
        b.out_ready = 1'b0;
        send(32'h00500093, 3'b000, 5'd5, 32'h00000005, 1'b0);
        send(32'h00600093, 3'b000, 5'd6, 32'h00000006, 1'b0);
        flush      = 1'b1;
        b.instr    = 32'h00900093;
        b.ImmSrc   = 3'b000;
        b.in_tag   = 5'd9;
        b.in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        b.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, b.in_ready}, 64'd1);
        @(posedge clk);
        #1 b.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_stays_empty", {63'd0, b.out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'hFFE00093, 3'b000, 5'd10, 32'hFFFFFFFE, 1'b0);
        drain();

        // Reset while holding one entry
        b.out_ready = 1'b0;
        send(32'h12345037, 3'b011, 5'd11, 32'h12345000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, b.in_ready}, 64'd1);
        chk("mid_rst_imm", {32'd0, b.ImmOp}, 64'd0);
        chk("mid_rst_ill", {63'd0, b.imm_illegal}, 64'd0);
        chk("mid_rst_tag", {59'd0, b.out_tag}, 64'd0);
        @(posedge clk);
        #1 b.out_ready = 1'b1;
        send(32'hFE000EE3, 3'b010, 5'd12, 32'hFFFFFFFC, 1'b0);
        @(negedge clk);
        chk("post_rst_latency", {63'd0, b.out_valid}, 64'd1);
        drain();

        // 64-bit instance: extension above bit 31
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ins64;
            logic [2:0]  src64;
            logic [63:0] e64;
            case (k)
                0:       begin ins64 = 32'h80000537; src64 = 3'b011; e64 = 64'hFFFFFFFF80000000; end
                1:       begin ins64 = 32'hFFF00093; src64 = 3'b000; e64 = 64'hFFFFFFFFFFFFFFFF; end
                default: begin ins64 = 32'hFFFFF06F; src64 = 3'b100; e64 = 64'hFFFFFFFFFFFFFFFE; end
            endcase
            @(posedge clk);
            #1 b64.instr = ins64;
            b64.ImmSrc   = src64;
            b64.in_tag   = 5'(k + 20);
            b64.in_valid = 1'b1;
            @(posedge clk);
            #1 b64.in_valid = 1'b0;
            @(negedge clk);
            chk("x64_out_valid", {63'd0, b64.out_valid}, 64'd1);
            chk("x64_imm", b64.ImmOp, e64);
            chk("x64_tag", {59'd0, b64.out_tag}, 64'(k + 20));
        end

        repeat (3) @(posedge clk);
        #1 chk("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Decode-stage immediate generator and the parametrised successor of the two-format extender. It covers all RV32I immediate formats (I/S/B/U/J) and sign-extends to a configurable XLEN. The result is registered behind a valid/ready interface with a 2-entry skid buffer, so `in_ready` is a registered signal. It sits between instruction memory/decode and the ALU-source/PC-target muxes, and carries a sideband tag alongside each result.

Parameters:
data_width, 32, XLEN of ImmOp; must be >= 32 (32 or 64 in use)
tag_width, 5, width of sideband tag carried with each immediate (e.g. rd)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush; discards all buffered entries
in_valid  input  1  instr/ImmSrc/in_tag valid this cycle
in_ready  output  1  block can accept an entry this cycle (registered)
instr  input  32  instruction word from Instr Mem
ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
in_tag  input  tag_width  sideband tag, passed through unmodified
out_valid  output  1  ImmOp/imm_illegal/out_tag valid
out_ready  input  1  consumer accepts output this cycle
ImmOp  output  data_width  extended immediate, to PC adder and ALUsrc mux
imm_illegal  output  1  entry was presented with an illegal ImmSrc
out_tag  output  tag_width  tag of the entry on ImmOp

Behaviour:
- Clocking: one clock, `clk`. Reset `rst` is synchronous and active-high. `flush` is also synchronous.
- Reset values: out_valid=0, in_ready=1, ImmOp=0, imm_illegal=0, out_tag=0, state EMPTY.
- Formats, with S(x) meaning sign-extension of x to data_width:
  - I: S(instr[31:20])
  - S: S({instr[31:25],instr[11:7]})
  - B: S({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - U: S({instr[31:12],12'b0}); bits above 31 are copies of instr[31]
  - J: S({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - Illegal ImmSrc: ImmOp=0, imm_illegal=1. Otherwise imm_illegal=0.
- Extension is combinational on the input side and is captured at accept.
- Handshakes:
  - Accept on the input = in_valid & in_ready.
  - Transfer on the output = out_valid & out_ready.
  - Latency: an accepted entry appears on the outputs the next cycle at the earliest.
- State machine, held in a main register plus a skid register:
  - EMPTY (out_valid=0, in_ready=1):
    - accept -> ONE, main<=entry.
  - ONE (out_valid=1, in_ready=1):
    - accept & transfer -> ONE, main<=new entry.
    - accept & !transfer -> FULL, skid<=new entry.
    - !accept & transfer -> EMPTY.
    - otherwise hold.
  - FULL (out_valid=1, in_ready=0):
    - transfer -> ONE, main<=skid.
    - otherwise hold. No input is accepted.
- in_ready = (state != FULL), driven from the state register only. No combinational path from out_ready to in_ready.
- While out_valid=1 and transfer has not occurred, ImmOp, imm_illegal and out_tag are stable.
- Ordering: entries leave in acceptance order. No loss or duplication.
- Priority: rst > flush > normal operation.
  - flush=1: next state EMPTY, out_valid=0, in_ready=1.
  - Any in_valid presented in the flush cycle is dropped, even if in_ready was 1.
  - Any output transfer in the flush cycle is still considered consumed by the downstream.
- Reset asserted mid-operation: same effect as flush, plus data registers clear to 0.
- On empty, data registers hold their last value (not required to clear). The bench must check data only when out_valid=1.

Test Plan:
1. I-type, out_ready=1: instr=0xFFF00093, ImmSrc=000, tag=1 -> next cycle out_valid=1, ImmOp=0xFFFFFFFF, imm_illegal=0, out_tag=1. Then EMPTY.
2. B and U formats: 0xFE000EE3/010 -> ImmOp=0xFFFFFFFC. 0x12345037/011 -> 0x12345000. With data_width=64: 0x80000537/011 -> 0xFFFFFFFF80000000.
3. Illegal format: ImmSrc=101, any instr -> ImmOp=0, imm_illegal=1, out_valid=1.
4. Backpressure: out_ready=0, back-to-back A,B,C (I-type, tags 1,2,3).
   - Cycle after B is accepted: in_ready=0, and C is held by the source.
   - Then out_ready=1: outputs are A, B, C in order, each exactly once.
   - in_ready returns to 1 the cycle after A transfers.
5. Flush when FULL, with in_valid=1 that cycle -> next cycle out_valid=0, in_ready=1. Flushed entries and the input from that cycle never appear.
6. rst=1 for one cycle while ONE with out_ready=0 -> next cycle all outputs equal their reset values. A new accept afterwards produces a correct result with 1-cycle latency.
